// File: rtl/image_raster_reader.sv
// Raster source: streams an imRow x imCol frame from a 1-cycle-latency pixel memory with valid/ready.
// Optional RASTER_FLUSH_EN appends zero beats after the image to push out the final downstream windows.
module image_raster_reader #(
   parameter int imRow     = 480,
   parameter int imCol     = 700,
   parameter int winRow    = 16,
   parameter int winCol    = 16,
   parameter int bitwidth  = 8,
   parameter int addrWidth = 20
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic [addrWidth-1:0] baseAddr_i,
   output logic                 memRdEn_o,
   output logic [addrWidth-1:0] memAddr_o,
   input  logic [bitwidth-1:0]  memData_i,
   output logic [bitwidth-1:0]  dataOut_o,
   output logic                 dataValid_o,
   input  logic                 ready_i,
   output logic                 lineStart_o,
   output logic                 frameStart_o,
   output logic                 lastPixel_o,
   output logic                 busy_o,
   output logic                 done_o
);
   localparam int ROW_W = (imRow > 1) ? $clog2(imRow) : 1;
   localparam int COL_W = (imCol > 1) ? $clog2(imCol) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(imRow - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(imCol - 1);

`ifdef RASTER_FLUSH_EN
   localparam int FL_LEN = (winRow - 1) * imCol + winCol;
   localparam int FL_W   = $clog2(FL_LEN + 1);
   localparam logic [FL_W-1:0] FL_END  = FL_W'(FL_LEN);
   localparam logic [FL_W-1:0] FL_LAST = FL_W'(FL_LEN - 1);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;
   logic [FL_W-1:0] fl_cnt_q, fl_cnt_d;
   logic            fl_push;
`else
   typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;
`endif

   state_t               state_q, state_d;
   logic [addrWidth-1:0] addr_q, addr_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic                 rd_done_q, rd_done_d;
   logic                 pend_q, pend_ls_q, pend_fs_q, pend_lp_q;
   logic                 pend_ls_d, pend_fs_d, pend_lp_d;

   // Two-entry skid FIFO holding returned pixels and their tags
   logic [bitwidth-1:0]  fifo_data_q [2];
   logic                 fifo_ls_q [2];
   logic                 fifo_fs_q [2];
   logic                 fifo_lp_q [2];
   logic                 wr_ptr_q, rd_ptr_q;
   logic [1:0]           cnt_q;

   logic                 pop, push, rd_issue, rd_last;
   logic [2:0]           occ;
   logic [bitwidth-1:0]  push_data;
   logic                 push_ls, push_fs, push_lp;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      row_d     = row_q;
      col_d     = col_q;
      rd_done_d = rd_done_q;
      pend_ls_d = 1'b0;
      pend_fs_d = 1'b0;
      pend_lp_d = 1'b0;
      pop       = (cnt_q != 2'd0) && ready_i;
      // Occupancy after this cycle's pop, counting the read already in flight
      occ       = 3'(pend_q) + 3'(cnt_q) - 3'(pop);
      rd_last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
      rd_issue  = (state_q == S_READ) && !rd_done_q && (occ < 3'd2);
      push      = pend_q;
      push_data = memData_i;
      push_ls   = pend_ls_q;
      push_fs   = pend_fs_q;
      push_lp   = pend_lp_q;
`ifdef RASTER_FLUSH_EN
      fl_cnt_d  = fl_cnt_q;
      fl_push   = (state_q == S_FLUSH) && (fl_cnt_q != FL_END) && ((cnt_q != 2'd2) || pop);
      if (fl_push) begin
         push      = 1'b1;
         push_data = '0;
         push_ls   = 1'b0;
         push_fs   = 1'b0;
         push_lp   = (fl_cnt_q == FL_LAST);
         fl_cnt_d  = fl_cnt_q + FL_W'(1);
      end
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_READ;
               addr_d    = baseAddr_i;
               row_d     = '0;
               col_d     = '0;
               rd_done_d = 1'b0;
`ifdef RASTER_FLUSH_EN
               fl_cnt_d  = '0;
`endif
            end
         end
         S_READ: begin
            if (rd_issue) begin
               addr_d    = addr_q + addrWidth'(1);
               pend_ls_d = (col_q == '0);
               pend_fs_d = (col_q == '0) && (row_q == '0);
`ifndef RASTER_FLUSH_EN
               pend_lp_d = rd_last;
`endif
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
               if (rd_last) rd_done_d = 1'b1;
            end
`ifdef RASTER_FLUSH_EN
            if (rd_done_q && !pend_q) state_d = S_FLUSH;
`else
            if (rd_done_q && !pend_q && (cnt_q == 2'd1) && pop) state_d = S_DONE;
`endif
         end
`ifdef RASTER_FLUSH_EN
         S_FLUSH: begin
            if ((fl_cnt_q == FL_END) && (cnt_q == 2'd1) && pop) state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         rd_done_q <= 1'b0;
         pend_q    <= 1'b0;
         pend_ls_q <= 1'b0;
         pend_fs_q <= 1'b0;
         pend_lp_q <= 1'b0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         cnt_q     <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_q[i] <= '0;
            fifo_ls_q[i]   <= 1'b0;
            fifo_fs_q[i]   <= 1'b0;
            fifo_lp_q[i]   <= 1'b0;
         end
`ifdef RASTER_FLUSH_EN
         fl_cnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         row_q     <= row_d;
         col_q     <= col_d;
         rd_done_q <= rd_done_d;
         pend_q    <= rd_issue;
         pend_ls_q <= pend_ls_d;
         pend_fs_q <= pend_fs_d;
         pend_lp_q <= pend_lp_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_ls_q[wr_ptr_q]   <= push_ls;
            fifo_fs_q[wr_ptr_q]   <= push_fs;
            fifo_lp_q[wr_ptr_q]   <= push_lp;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
`ifdef RASTER_FLUSH_EN
         fl_cnt_q  <= fl_cnt_d;
`endif
      end
   end

   assign memRdEn_o    = rd_issue;
   assign memAddr_o    = addr_q;
   assign dataValid_o  = (cnt_q != 2'd0);
   assign dataOut_o    = fifo_data_q[rd_ptr_q];
   assign lineStart_o  = dataValid_o && fifo_ls_q[rd_ptr_q];
   assign frameStart_o = dataValid_o && fifo_fs_q[rd_ptr_q];
   assign lastPixel_o  = dataValid_o && fifo_lp_q[rd_ptr_q];
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
endmodule

// File: tb/tb_image_raster_reader.sv
// Directed bench for image_raster_reader on a 4x5 frame; honours RASTER_FLUSH_EN (winRow=3, winCol=3).
module tb_image_raster_reader;
   localparam int NPIX = 20;
`ifdef RASTER_FLUSH_EN
   localparam int TOTAL = NPIX + (3 - 1) * 5 + 3;
`else
   localparam int TOTAL = NPIX;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        ready = 1'b0;
   logic [19:0] base_addr = '0;
   logic        mem_rd_en;
   logic [19:0] mem_addr;
   logic [7:0]  mem_data = '0;
   logic [7:0]  data_out;
   logic        data_valid, line_start, frame_start, last_pixel, busy, done;

   int n_vec  = 0;
   int n_miss = 0;

   image_raster_reader #(
      .imRow(4), .imCol(5), .winRow(3), .winCol(3), .bitwidth(8), .addrWidth(20)
   ) dut (
      .clock_i(clock), .reset_i(reset), .start_i(start), .baseAddr_i(base_addr),
      .memRdEn_o(mem_rd_en), .memAddr_o(mem_addr), .memData_i(mem_data),
      .dataOut_o(data_out), .dataValid_o(data_valid), .ready_i(ready),
      .lineStart_o(line_start), .frameStart_o(frame_start), .lastPixel_o(last_pixel),
      .busy_o(busy), .done_o(done)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] pix_of(input logic [19:0] a);
      return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h3c;
   endfunction

   always @(posedge clock) if (mem_rd_en) mem_data <= pix_of(mem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: random ready
   task automatic run_frame(input logic [19:0] base, input int mode, input int start_at,
                            input int rst_at, input string name);
      int c, bi, ri, last_acc_c, first_v_c, buf_cnt, done_cnt;
      logic prev_rd, prev_stall, accept, fin, injected, aborted;
      logic [7:0]  prev_d, exp_d;
      logic [2:0]  prev_tags;
      logic [19:0] exp_a;
      c = 0; bi = 0; ri = 0; last_acc_c = -10; first_v_c = -1; buf_cnt = 0; done_cnt = 0;
      prev_rd = 0; prev_stall = 0; fin = 0; injected = 0; aborted = 0;
      prev_d = '0; prev_tags = '0;
      @(negedge clock);
      start = 1'b1; base_addr = base; ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      while (!fin && c < 600) begin
         start = 1'b0;
         case (mode)
            0:       ready = 1'b1;
            1:       ready = ((c % 4) == 0) || ((c % 4) == 3);
            default: ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (c == 0) chk({name, " busy after start"}, 32'(busy), 32'd1);
         accept = data_valid && ready;
         if (prev_stall) begin
            chk({name, " hold valid"}, 32'(data_valid), 32'd1);
            chk({name, " hold data"}, 32'(data_out), 32'(prev_d));
            chk({name, " hold tags"}, 32'({line_start, frame_start, last_pixel}), 32'(prev_tags));
         end
         if (mem_rd_en) begin
            exp_a = base + 20'(ri);
            chk({name, " addr"}, 32'(mem_addr), 32'(exp_a));
            chk({name, " pending<2"}, 32'((buf_cnt + int'(prev_rd) - int'(accept)) < 2), 32'd1);
            ri++;
         end
         if (data_valid && first_v_c < 0) first_v_c = c;
         if (rst_at >= 0 && bi == rst_at) begin
            reset = 1'b0;
            @(negedge clock); #1;
            chk({name, " rst outputs"},
                32'({mem_rd_en, data_valid, line_start, frame_start, last_pixel, busy, done}), 32'd0);
            chk({name, " rst data/addr"}, 32'({data_out, mem_addr}), 32'd0);
            reset = 1'b1;
            aborted = 1; fin = 1;
         end else begin
            if (accept) begin
               if (bi < NPIX) exp_d = pix_of(base + 20'(bi));
               else           exp_d = '0;
               chk({name, " beat range"}, 32'(bi < TOTAL), 32'd1);
               chk({name, " data"}, 32'(data_out), 32'(exp_d));
               chk({name, " tags"}, 32'({line_start, frame_start, last_pixel}),
                   32'({bi < NPIX && (bi % 5) == 0, bi == 0, bi == TOTAL - 1}));
               last_acc_c = c;
               bi++;
            end
            if (done) begin
               done_cnt++;
               chk({name, " beats at done"}, 32'(bi), 32'(TOTAL));
               chk({name, " done latency"}, 32'(c - last_acc_c), 32'd1);
               chk({name, " busy at done"}, 32'(busy), 32'd1);
               fin = 1;
            end else if (!fin) begin
               chk({name, " busy"}, 32'(busy), 32'd1);
            end
            if (start_at >= 0 && bi == start_at && !injected) begin
               start = 1'b1; base_addr = ~base; injected = 1;
            end
            buf_cnt = buf_cnt + int'(prev_rd) - int'(accept);
            prev_rd = mem_rd_en;
            prev_stall = data_valid && !ready;
            prev_d = data_out;
            prev_tags = {line_start, frame_start, last_pixel};
            c++;
            @(negedge clock);
         end
      end
      start = 1'b0;
      if (!fin) chk({name, " timeout"}, 32'd0, 32'd1);
      if (!aborted) begin
         chk({name, " reads"}, 32'(ri), 32'(NPIX));
         if (mode == 0) chk({name, " first valid"}, 32'(first_v_c), 32'd2);
      end
      for (int t = 0; t < 4; t++) begin
         #1;
         chk({name, " idle busy"}, 32'(busy), 32'd0);
         chk({name, " idle done"}, 32'(done), 32'd0);
         @(negedge clock);
      end
      $display("frame %s: base=0x%05h beats=%0d reads=%0d cycles=%0d done=%0d",
               name, base, bi, ri, c, done_cnt);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      chk("reset outputs",
          32'({mem_rd_en, data_valid, line_start, frame_start, last_pixel, busy, done}), 32'd0);
      reset = 1'b1;
      run_frame(20'h00100, 0, -1, -1, "plain");
      run_frame(20'h00100, 1, -1, -1, "stall");
      run_frame(20'hFFFFD, 0, -1, -1, "wrap");
      run_frame(20'h00100, 0,  7, -1, "restart");
      run_frame(20'h00100, 0, -1,  9, "reset");
      run_frame(20'h00100, 0, -1, -1, "replay");
      run_frame(20'h00ABC, 2, -1, -1, "random");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
